// File: rtl/nano_mem_pkg.sv
// Shared types for the nano data-memory responder: FSM states and error causes.
package nano_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int unsigned ERR_W        = 3;
    localparam int unsigned ERR_RW_BOTH  = 0;
    localparam int unsigned ERR_MISALIGN = 1;
    localparam int unsigned ERR_RANGE    = 2;

    typedef logic [ERR_W-1:0] err_cause_t;

    // One bit per cause; any set bit makes the access an errored access.
    function automatic err_cause_t err_cause(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        err_cause_t c;
        c               = '0;
        c[ERR_RW_BOTH]  = rd & wr;
        c[ERR_MISALIGN] = |addr[1:0];
        c[ERR_RANGE]    = ({2'b00, addr[31:2]} >= depth);
        return c;
    endfunction

endpackage

// File: rtl/nano_ram_array.sv
// Word storage with per-byte write enables and a combinational read port.
module nano_ram_array #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned AW          = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/nano_dmem_resp.sv
// Data-memory responder: accepts one LSU access, inserts wait states, then
// returns a one-cycle ready strobe with read data or an error flag.
module nano_dmem_resp
    import nano_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic [3:0]  d_be_i,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    output logic [31:0] d_data_o,
    output logic        d_ready_o,
    output logic        d_err_o
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH     = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;

    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          rd_q;
    logic          wr_q;
    err_cause_t    cause_q;

    err_cause_t    cause_in;
    err_cause_t    cur_cause;
    logic [AW-1:0] cur_idx;
    logic          cur_rd;
    logic          finish;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    // With zero wait states the response is built straight from the incoming
    // request, so the current access is taken from the inputs while idle.
    always_comb begin
        cause_in = err_cause(d_rd_i, d_wr_i, d_addr_i, DEPTH);
        if (state == ST_IDLE) begin
            cur_idx   = d_addr_i[AW+1:2];
            cur_rd    = d_rd_i;
            cur_cause = cause_in;
        end else begin
            cur_idx   = idx_q;
            cur_rd    = rd_q;
            cur_cause = cause_q;
        end
    end

    assign finish = ((state == ST_IDLE) && (d_rd_i || d_wr_i) && (WAIT_CYCLES == 0))
                 || ((state == ST_WAIT) && (cnt == '0));

    assign ram_we = (state == ST_RESP) && wr_q && (cause_q == '0) && !rst_i;

    nano_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .be    (be_q),
        .addr  (cur_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            d_ready_o <= 1'b0;
            d_err_o   <= 1'b0;
            d_data_o  <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cause_q   <= '0;
        end else begin
            d_ready_o <= finish;
            d_err_o   <= finish && (cur_cause != '0);
            if (finish) begin
                if (cur_cause != '0) begin
                    d_data_o <= '0;
                end else if (cur_rd) begin
                    d_data_o <= ram_rdata;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (d_rd_i || d_wr_i) begin
                        idx_q   <= d_addr_i[AW+1:2];
                        wdata_q <= d_data_i;
                        be_q    <= d_be_i;
                        rd_q    <= d_rd_i;
                        wr_q    <= d_wr_i;
                        cause_q <= cause_in;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nano_dmem_resp.sv
// Randomized bench for nano_dmem_resp: three instances (0, 1 and 3 wait
// states) checked against a word-array reference model.
module tb_nano_dmem_resp;

    localparam int unsigned WAITS [3] = '{0, 1, 3};

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [2:0]  rdy;
    logic [2:0]  erro;
    logic [31:0] dout [3];

    logic [31:0] model    [3][32];
    logic [31:0] exp_dout [3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        nano_dmem_resp #(
            .DEPTH_WORDS (32),
            .WAIT_CYCLES (WAITS[g])
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .d_addr_i  (addr),
            .d_data_i  (wdata),
            .d_be_i    (be),
            .d_rd_i    (rd[g]),
            .d_wr_i    (wr[g]),
            .d_data_o  (dout[g]),
            .d_ready_o (rdy[g]),
            .d_err_o   (erro[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One complete access on instance s; request held until ready is seen.
    task automatic do_access(input int s, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int unsigned k;
        bit          e;
        addr  = a;
        wdata = d;
        be    = b;
        rd[s] = r;
        wr[s] = w;
        @(posedge clk); #1;
        k = 0;
        while (!rdy[s] && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        e = (r && w) || (a[1:0] != 2'b00) || (a[31:2] >= 30'd32);
        if (e) begin
            exp_dout[s] = '0;
        end else begin
            if (r) exp_dout[s] = model[s][a[6:2]];
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) model[s][a[6:2]][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        check("latency", 32'(k), 32'(WAITS[s]));
        check("err", 32'(erro[s]), 32'(e));
        check("data", dout[s], exp_dout[s]);
        @(posedge clk); #1;
        check("ready_pulse", 32'(rdy[s]), 32'd0);
        check("data_hold", dout[s], exp_dout[s]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          s;
        int unsigned r;
        int unsigned op;
        logic [31:0] a;

        rst   = 1'b1;
        rd    = '0;
        wr    = '0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        for (int i = 0; i < 3; i++) exp_dout[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(rdy[i]), 32'd0);
            check("rst_err", 32'(erro[i]), 32'd0);
            check("rst_data", dout[i], 32'd0);
        end
        rst = 1'b0;

        // Known contents everywhere before anything is read back.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 32; j++) begin
                do_access(i, 1'b0, 1'b1, 32'(j) << 2, $urandom, 4'hF);
            end
        end

        do_access(1, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
        do_access(1, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        check("rw_deadbeef", dout[1], 32'hDEADBEEF);

        do_access(1, 1'b0, 1'b1, 32'h04, 32'h11223344, 4'hF);
        do_access(1, 1'b0, 1'b1, 32'h04, 32'h0000AA00, 4'b0010);
        do_access(1, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        check("be_merge", dout[1], 32'h1122AA44);

        do_access(1, 1'b0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'b0000);
        do_access(1, 1'b1, 1'b0, 32'h06, 32'h0, 4'h0);
        check("misalign_data", dout[1], 32'h0);
        do_access(1, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
        check("range_data", dout[1], 32'h0);
        do_access(1, 1'b0, 1'b1, 32'h80, 32'h12345678, 4'hF);
        do_access(1, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        check("storage_kept", dout[1], 32'h1122AA44);

        do_access(1, 1'b1, 1'b1, 32'h08, 32'h0, 4'hF);
        do_access(1, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        check("rw_both_nowrite", dout[1], 32'hDEADBEEF);

        for (int n = 0; n < 200; n++) begin
            s  = int'($urandom_range(0, 2));
            op = $urandom_range(0, 9);
            r  = $urandom_range(0, 9);
            case (r)
                7:       a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
                8:       a = 32'($urandom_range(32, 100000)) << 2;
                9:       a = $urandom;
                default: a = 32'($urandom_range(0, 31)) << 2;
            endcase
            do_access(s, (op < 5) || (op == 9), (op >= 5), a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during the second wait cycle aborts a pending write.
        addr  = 32'h0C;
        wdata = 32'h5;
        be    = 4'hF;
        wr[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst   = 1'b1;
        wr[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) exp_dout[i] = '0;
        check("abort_rst_data", dout[2], 32'h0);
        check("abort_rst_err", 32'(erro[2]), 32'd0);
        r = 0;
        for (int i = 0; i < 8; i++) begin
            r += 32'(rdy[2]);
            @(posedge clk); #1;
        end
        check("abort_no_ready", r, 32'd0);
        do_access(2, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);

        // Back-to-back reads with zero wait states: one strobe every 2 cycles.
        addr  = 32'h10;
        rd[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("b2b_ready", 32'(rdy[0]), 32'((i % 2) == 0));
        end
        rd[0] = 1'b0;
        @(posedge clk); #1;
        check("b2b_data", dout[0], model[0][4]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
